// File: rtl/lcd_bus_arbiter.sv
// Round-robin arbiter and HD44780 write sequencer for two clients sharing one character-LCD bus.
// Generates setup/enable/hold timing and the post-write execution wait, then pulses done to the owner.
module lcd_bus_arbiter #(
  parameter int SETUP_CYC = 4,
  parameter int EN_CYC    = 12,
  parameter int HOLD_CYC  = 4,
  parameter int EXEC_CYC  = 2000,
  parameter int CLR_CYC   = 80000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       rs0,
  input  logic [7:0] data0,
  output logic       gnt0,
  output logic       done0,
  input  logic       req1,
  input  logic       rs1,
  input  logic [7:0] data1,
  output logic       gnt1,
  output logic       done1,
  output logic       busy,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic [7:0] lcd_data
);

  localparam logic [19:0] SETUP_LD = 20'(SETUP_CYC - 1);
  localparam logic [19:0] EN_LD    = 20'(EN_CYC - 1);
  localparam logic [19:0] HOLD_LD  = 20'(HOLD_CYC - 1);
  localparam logic [19:0] EXEC_LD  = 20'(EXEC_CYC - 1);
  localparam logic [19:0] CLR_LD   = 20'(CLR_CYC - 1);

  typedef enum logic [2:0] {IDLE, SETUP, ENABLE, HOLD, EXEC} state_t;

  state_t      state, state_nxt;
  logic [19:0] cnt, cnt_nxt;
  logic        owner, owner_nxt;
  logic        last_grant, last_grant_nxt;
  logic        gnt0_nxt, gnt1_nxt, done0_nxt, done1_nxt;
  logic        lcd_rs_nxt, lcd_en_nxt;
  logic [7:0]  lcd_data_nxt;
  logic        pick0, pick1, is_clr, cnt_zero;

  // Client 0 wins when alone or when client 1 had the previous grant.
  assign pick0    = req0 && (!req1 || last_grant);
  assign pick1    = req1 && !pick0;
  // Clear display / return home need the long execution wait.
  assign is_clr   = !lcd_rs && (lcd_data[7:2] == 6'd0);
  assign cnt_zero = (cnt == 20'd0);
  assign busy     = (state != IDLE);
  assign lcd_rw   = 1'b0;

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    owner_nxt      = owner;
    last_grant_nxt = last_grant;
    gnt0_nxt       = 1'b0;
    gnt1_nxt       = 1'b0;
    done0_nxt      = 1'b0;
    done1_nxt      = 1'b0;
    lcd_rs_nxt     = lcd_rs;
    lcd_data_nxt   = lcd_data;
    lcd_en_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (pick0) begin
          gnt0_nxt       = 1'b1;
          lcd_rs_nxt     = rs0;
          lcd_data_nxt   = data0;
          owner_nxt      = 1'b0;
          last_grant_nxt = 1'b0;
          state_nxt      = SETUP;
          cnt_nxt        = SETUP_LD;
        end else if (pick1) begin
          gnt1_nxt       = 1'b1;
          lcd_rs_nxt     = rs1;
          lcd_data_nxt   = data1;
          owner_nxt      = 1'b1;
          last_grant_nxt = 1'b1;
          state_nxt      = SETUP;
          cnt_nxt        = SETUP_LD;
        end
      end
      SETUP: begin
        if (cnt_zero) begin
          state_nxt  = ENABLE;
          cnt_nxt    = EN_LD;
          lcd_en_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt - 20'd1;
        end
      end
      ENABLE: begin
        lcd_en_nxt = 1'b1;
        if (cnt_zero) begin
          state_nxt  = HOLD;
          cnt_nxt    = HOLD_LD;
          lcd_en_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt - 20'd1;
        end
      end
      HOLD: begin
        if (cnt_zero) begin
          state_nxt = EXEC;
          cnt_nxt   = is_clr ? CLR_LD : EXEC_LD;
        end else begin
          cnt_nxt = cnt - 20'd1;
        end
      end
      EXEC: begin
        if (cnt_zero) begin
          state_nxt = IDLE;
          done0_nxt = !owner;
          done1_nxt = owner;
        end else begin
          cnt_nxt = cnt - 20'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 20'd0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      lcd_rs     <= 1'b0;
      lcd_en     <= 1'b0;
      lcd_data   <= 8'h00;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      owner      <= owner_nxt;
      last_grant <= last_grant_nxt;
      gnt0       <= gnt0_nxt;
      gnt1       <= gnt1_nxt;
      done0      <= done0_nxt;
      done1      <= done1_nxt;
      lcd_rs     <= lcd_rs_nxt;
      lcd_en     <= lcd_en_nxt;
      lcd_data   <= lcd_data_nxt;
    end
  end

endmodule
